// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - request/message/directory encodings and FSM state type for the directory controller
package dir_pkg;

  typedef enum logic [1:0] {
    REQ_READ_MISS  = 2'b00,
    REQ_WRITE_MISS = 2'b01,
    REQ_INVALIDATE = 2'b10,
    REQ_WRITE_BACK = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    MSG_DATA_REPLY = 2'b00,
    MSG_INVALIDATE = 2'b01,
    MSG_FETCH      = 2'b10,
    MSG_FETCH_INV  = 2'b11
  } msg_type_e;

  typedef enum logic [1:0] {
    DIR_UNCACHED  = 2'b01,
    DIR_SHARED    = 2'b10,
    DIR_EXCLUSIVE = 2'b11
  } dir_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_SEND_INV,
    ST_SEND_FETCH,
    ST_WAIT_WB,
    ST_REPLY
  } fsm_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/dir_entry_array.sv
// rtl/dir_entry_array.sv - per-block directory state and sharer storage, one async read port, one write port
module dir_entry_array
  import dir_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int NUM_BLOCKS = 8,
  localparam int ADDR_W    = $clog2(NUM_BLOCKS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    i_raddr,
  output dir_state_e           o_rstate,
  output logic [NUM_NODES-1:0] o_rsharers,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  dir_state_e           i_wstate,
  input  logic [NUM_NODES-1:0] i_wsharers
);

  dir_state_e           r_state   [NUM_BLOCKS];
  logic [NUM_NODES-1:0] r_sharers [NUM_BLOCKS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_state[i]   <= DIR_UNCACHED;
        r_sharers[i] <= '0;
      end
    end else if (i_we) begin
      r_state[i_waddr]   <= i_wstate;
      r_sharers[i_waddr] <= i_wsharers;
    end
  end

  assign o_rstate   = r_state[i_raddr];
  assign o_rsharers = r_sharers[i_raddr];

endmodule

// File: rtl/directory_controller.sv
// rtl/directory_controller.sv - MSI-style coherence directory controller
// Defining DIR_STATS_EN adds saturating stat_req_count / stat_inv_count outputs.
module directory_controller
  import dir_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int NUM_BLOCKS = 8,
  localparam int ADDR_W    = $clog2(NUM_BLOCKS),
  localparam int NODE_W    = $clog2(NUM_NODES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [NODE_W-1:0]    req_node,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [1:0]           msg_type,
  output logic [NUM_NODES-1:0] msg_dest,
  output logic [ADDR_W-1:0]    msg_addr,
  input  logic                 wb_valid
`ifdef DIR_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_req_count,
  output logic [STAT_W-1:0]    stat_inv_count
`endif
);

  fsm_state_e           r_state, w_next;
  req_type_e            r_type;
  logic [NODE_W-1:0]    r_node;
  logic [ADDR_W-1:0]    r_addr;
  logic [NUM_NODES-1:0] r_dest, w_dest;
  logic                 r_fetch_inv, w_fetch_inv;
  logic                 r_reply, w_reply;
  dir_state_e           r_new_state, w_new_state;
  logic [NUM_NODES-1:0] r_new_sharers, w_new_sharers;

  dir_state_e           w_dstate;
  logic [NUM_NODES-1:0] w_sharers, w_req_mask, w_others;
  logic                 w_is_owner, w_we, w_msg_valid;
  msg_type_e            w_msg_type;
  logic [NUM_NODES-1:0] w_msg_dest;

  dir_entry_array #(.NUM_NODES(NUM_NODES), .NUM_BLOCKS(NUM_BLOCKS)) u_array (
    .clock      (clock),
    .reset      (reset),
    .i_raddr    (r_addr),
    .o_rstate   (w_dstate),
    .o_rsharers (w_sharers),
    .i_we       (w_we),
    .i_waddr    (r_addr),
    .i_wstate   (w_new_state),
    .i_wsharers (w_new_sharers)
  );

  assign w_req_mask = NUM_NODES'(1) << r_node;
  assign w_others   = w_sharers & ~w_req_mask;
  assign w_is_owner = (w_dstate == DIR_EXCLUSIVE) && (w_sharers == w_req_mask);
  assign req_ready  = (r_state == ST_IDLE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_we          = 1'b0;
    w_msg_valid   = 1'b0;
    w_msg_type    = MSG_DATA_REPLY;
    w_msg_dest    = '0;
    w_dest        = r_dest;
    w_fetch_inv   = r_fetch_inv;
    w_reply       = r_reply;
    w_new_state   = r_new_state;
    w_new_sharers = r_new_sharers;
    case (r_state)
      ST_IDLE: if (req_valid && req_ready) w_next = ST_LOOKUP;
      ST_LOOKUP: begin
        // Decide the whole transaction here; the entry is rewritten only when it completes.
        w_next = ST_REPLY;
        if (r_type == REQ_WRITE_BACK) begin
          w_next        = ST_IDLE;
          w_we          = w_is_owner;
          w_new_state   = DIR_UNCACHED;
          w_new_sharers = '0;
        end else begin
          case (w_dstate)
            DIR_SHARED: begin
              if (r_type == REQ_READ_MISS) begin
                w_new_state   = DIR_SHARED;
                w_new_sharers = w_sharers | w_req_mask;
              end else begin
                w_new_state   = DIR_EXCLUSIVE;
                w_new_sharers = w_req_mask;
                w_reply       = !((r_type == REQ_INVALIDATE) && |(w_sharers & w_req_mask));
                w_dest        = w_others;
                if (|w_others) w_next = ST_SEND_INV;
                else if (!w_reply) begin
                  w_next = ST_IDLE;
                  w_we   = 1'b1;
                end
              end
            end
            DIR_EXCLUSIVE: begin
              w_new_state = (r_type == REQ_READ_MISS) ? DIR_SHARED : DIR_EXCLUSIVE;
              if (w_is_owner) begin
                w_new_sharers = w_req_mask;
              end else begin
                w_next        = ST_SEND_FETCH;
                w_dest        = w_sharers;
                w_fetch_inv   = (r_type != REQ_READ_MISS);
                w_new_sharers = (r_type == REQ_READ_MISS) ? (w_sharers | w_req_mask) : w_req_mask;
              end
            end
            default: begin
              w_new_state   = (r_type == REQ_READ_MISS) ? DIR_SHARED : DIR_EXCLUSIVE;
              w_new_sharers = w_req_mask;
            end
          endcase
        end
      end
      ST_SEND_INV: begin
        w_msg_valid = 1'b1;
        w_msg_type  = MSG_INVALIDATE;
        w_msg_dest  = r_dest;
        if (msg_ready) begin
          w_next = r_reply ? ST_REPLY : ST_IDLE;
          w_we   = !r_reply;
        end
      end
      ST_SEND_FETCH: begin
        w_msg_valid = 1'b1;
        w_msg_type  = r_fetch_inv ? MSG_FETCH_INV : MSG_FETCH;
        w_msg_dest  = r_dest;
        if (msg_ready) w_next = ST_WAIT_WB;
      end
      ST_WAIT_WB: if (wb_valid) w_next = ST_REPLY;
      ST_REPLY: begin
        w_msg_valid = 1'b1;
        w_msg_type  = MSG_DATA_REPLY;
        w_msg_dest  = w_req_mask;
        if (msg_ready) begin
          w_next = ST_IDLE;
          w_we   = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_type        <= REQ_READ_MISS;
      r_node        <= '0;
      r_addr        <= '0;
      r_dest        <= '0;
      r_fetch_inv   <= 1'b0;
      r_reply       <= 1'b0;
      r_new_state   <= DIR_UNCACHED;
      r_new_sharers <= '0;
    end else begin
      if (req_valid && req_ready) begin
        r_type <= req_type_e'(req_type);
        r_node <= req_node;
        r_addr <= req_addr;
      end
      r_dest        <= w_dest;
      r_fetch_inv   <= w_fetch_inv;
      r_reply       <= w_reply;
      r_new_state   <= w_new_state;
      r_new_sharers <= w_new_sharers;
    end
  end

  assign msg_valid = w_msg_valid;
  assign msg_type  = w_msg_type;
  assign msg_dest  = w_msg_dest;
  assign msg_addr  = w_msg_valid ? r_addr : '0;

`ifdef DIR_STATS_EN
  logic [STAT_W-1:0] r_req_count, r_inv_count;
  logic              w_inv_hs;

  assign w_inv_hs = msg_valid && msg_ready &&
                    (msg_type == MSG_INVALIDATE || msg_type == MSG_FETCH_INV);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_count <= '0;
      r_inv_count <= '0;
    end else begin
      if (req_valid && req_ready && !(&r_req_count)) r_req_count <= r_req_count + 1'b1;
      if (w_inv_hs && !(&r_inv_count))               r_inv_count <= r_inv_count + 1'b1;
    end
  end

  assign stat_req_count = r_req_count;
  assign stat_inv_count = r_inv_count;
`endif

endmodule

// File: tb/tb_directory_controller.sv
// tb/tb_directory_controller.sv - directed table, corner sequences and random traffic vs. a message-list model
module tb_directory_controller;

  localparam int NB = 8;
  localparam logic [1:0] RM = 2'b00, WM = 2'b01, IV = 2'b10, WB = 2'b11;
  localparam logic [1:0] DR = 2'b00, INV = 2'b01, FE = 2'b10, FI = 2'b11;
  localparam int UNC = 1, SHR = 2, EXC = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_type = 2'b00;
  logic [1:0] req_node = 2'b00;
  logic [2:0] req_addr = 3'b000;
  logic       msg_valid, msg_ready = 1'b0;
  logic [1:0] msg_type;
  logic [3:0] msg_dest;
  logic [2:0] msg_addr;
  logic       wb_valid = 1'b0;
`ifdef DIR_STATS_EN
  logic [15:0] stat_req_count, stat_inv_count;
`endif

  always #5 clock = ~clock;

  directory_controller #(.NUM_NODES(4), .NUM_BLOCKS(NB)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_node  (req_node),
    .req_addr  (req_addr),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_type  (msg_type),
    .msg_dest  (msg_dest),
    .msg_addr  (msg_addr),
    .wb_valid  (wb_valid)
`ifdef DIR_STATS_EN
    ,
    .stat_req_count (stat_req_count),
    .stat_inv_count (stat_inv_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         m_st[NB];
  logic [3:0] m_sh[NB];

  typedef struct {
    logic [1:0] t;
    int         n;
    int         a;
    int         cnt;
    logic [8:0] m0;
    logic [8:0] m1;
  } vec_t;
  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] mk(input logic [1:0] t, input logic [3:0] d, input int a);
    return {t, d, a[2:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = UNC;
      m_sh[i] = 4'b0000;
    end
  endtask

  // Expected message list and directory update for one request, from the protocol rules.
  task automatic model_req(input logic [1:0] t, input int n, input int a);
    logic [3:0] rm, sh, others;
    rm     = 4'(1 << n);
    sh     = m_sh[a];
    others = sh & ~rm;
    exp_q.delete();
    if (t == WB) begin
      if (m_st[a] == EXC && sh == rm) begin
        m_st[a] = UNC;
        m_sh[a] = 4'b0000;
      end
    end else if (m_st[a] == UNC) begin
      exp_q.push_back(mk(DR, rm, a));
      m_st[a] = (t == RM) ? SHR : EXC;
      m_sh[a] = rm;
    end else if (m_st[a] == SHR) begin
      if (t == RM) begin
        exp_q.push_back(mk(DR, rm, a));
        m_sh[a] = sh | rm;
      end else begin
        if (others != 0) exp_q.push_back(mk(INV, others, a));
        if (!(t == IV && (sh & rm) != 0)) exp_q.push_back(mk(DR, rm, a));
        m_st[a] = EXC;
        m_sh[a] = rm;
      end
    end else if (sh == rm) begin
      exp_q.push_back(mk(DR, rm, a));
      if (t == RM) m_st[a] = SHR;
    end else begin
      exp_q.push_back(mk((t == RM) ? FE : FI, sh, a));
      exp_q.push_back(mk(DR, rm, a));
      if (t == RM) begin
        m_st[a] = SHR;
        m_sh[a] = sh | rm;
      end else begin
        m_sh[a] = rm;
      end
    end
  endtask

  task automatic do_req(input logic [1:0] t, input int n, input int a, input int stall);
    int cyc, wb_cnt;
    bit waiting, early, saw_fetch, done;
    got_q.delete();
    wb_cnt = -1; waiting = 0; early = 0; saw_fetch = 0; done = 0; cyc = 0;
    @(negedge clock);
    req_valid = 1'b1; req_type = t; req_node = 2'(n); req_addr = 3'(a);
    while (!req_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    if (!req_ready) check("request accept timeout", 0, 1);
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 0;
    while (!done) begin
      if (req_ready) done = 1;
      else if (cyc >= 80) begin
        check("transaction timeout", 0, 1);
        done = 1;
      end else begin
        if (waiting && msg_valid) early = 1;
        wb_valid = (wb_cnt == 0);
        if (wb_valid) waiting = 0;
        if (wb_cnt >= 0) wb_cnt--;
        msg_ready = ($urandom_range(99) >= stall);
        if (msg_valid && msg_ready) begin
          got_q.push_back({msg_type, msg_dest, msg_addr});
          if (msg_type == FE || msg_type == FI) begin
            saw_fetch = 1; waiting = 1; wb_cnt = $urandom_range(3);
          end
        end
        @(negedge clock);
        cyc++;
      end
    end
    msg_ready = 1'b0;
    wb_valid  = 1'b0;
    if (saw_fetch) check("no reply before wb_valid", 32'(early), 0);
  endtask

  task automatic cmp_q(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s msg%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{RM, 0, 3, 1, mk(DR, 4'b0001, 3), 9'd0};
    tbl[1]  = '{RM, 1, 3, 1, mk(DR, 4'b0010, 3), 9'd0};
    tbl[2]  = '{WM, 2, 3, 2, mk(INV, 4'b0011, 3), mk(DR, 4'b0100, 3)};
    tbl[3]  = '{WM, 2, 5, 1, mk(DR, 4'b0100, 5), 9'd0};
    tbl[4]  = '{RM, 1, 5, 2, mk(FE, 4'b0100, 5), mk(DR, 4'b0010, 5)};
    tbl[5]  = '{IV, 1, 5, 1, mk(INV, 4'b0100, 5), 9'd0};
    tbl[6]  = '{WB, 1, 5, 0, 9'd0, 9'd0};
    tbl[7]  = '{RM, 3, 5, 1, mk(DR, 4'b1000, 5), 9'd0};
    tbl[8]  = '{IV, 0, 5, 2, mk(INV, 4'b1000, 5), mk(DR, 4'b0001, 5)};
    tbl[9]  = '{RM, 0, 5, 1, mk(DR, 4'b0001, 5), 9'd0};
    tbl[10] = '{WB, 3, 5, 0, 9'd0, 9'd0};
    tbl[11] = '{WM, 3, 5, 2, mk(INV, 4'b0001, 5), mk(DR, 4'b1000, 5)};
    tbl[12] = '{WM, 2, 5, 2, mk(FI, 4'b1000, 5), mk(DR, 4'b0100, 5)};
    tbl[13] = '{WM, 2, 5, 1, mk(DR, 4'b0100, 5), 9'd0};
    tbl[14] = '{WB, 1, 5, 0, 9'd0, 9'd0};
    tbl[15] = '{WB, 2, 5, 0, 9'd0, 9'd0};
    tbl[16] = '{RM, 3, 5, 1, mk(DR, 4'b1000, 5), 9'd0};
    tbl[17] = '{RM, 1, 6, 1, mk(DR, 4'b0010, 6), 9'd0};
    tbl[18] = '{IV, 1, 6, 0, 9'd0, 9'd0};
    tbl[19] = '{RM, 0, 6, 2, mk(FE, 4'b0010, 6), mk(DR, 4'b0001, 6)};
    tbl[20] = '{WM, 0, 6, 2, mk(INV, 4'b0010, 6), mk(DR, 4'b0001, 6)};

    model_reset();
    repeat (2) @(negedge clock);
    check("reset outputs", {msg_valid, req_ready, msg_type, msg_dest, msg_addr}, 11'd0);
    reset = 1'b0;
    @(negedge clock);
    check("req_ready after release", 32'(req_ready), 1);

    foreach (tbl[i]) begin
      model_req(tbl[i].t, tbl[i].n, tbl[i].a);
      exp_q.delete();
      if (tbl[i].cnt > 0) exp_q.push_back(tbl[i].m0);
      if (tbl[i].cnt > 1) exp_q.push_back(tbl[i].m1);
      do_req(tbl[i].t, tbl[i].n, tbl[i].a, 25);
      cmp_q($sformatf("row%0d", i));
    end

    // Stalled reply: fields frozen and no new request accepted.
    model_req(RM, 0, 0);
    @(negedge clock);
    req_valid = 1'b1; req_type = RM; req_node = 2'd0; req_addr = 3'd0; msg_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    check("no msg during lookup", {msg_valid, req_ready}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("stall cyc%0d", i), {msg_valid, req_ready, msg_type, msg_dest, msg_addr},
            {2'b10, mk(DR, 4'b0001, 0)});
    end
    msg_ready = 1'b1;
    @(negedge clock);
    msg_ready = 1'b0;
    check("idle after stalled reply", {msg_valid, req_ready}, 2'b01);

    // Reset while waiting for the owner's write-back.
    model_req(WM, 2, 1);
    do_req(WM, 2, 1, 0);
    cmp_q("setup b1");
    @(negedge clock);
    req_valid = 1'b1; req_type = RM; req_node = 2'd1; req_addr = 3'd1; msg_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("fetch to owner", {msg_valid, msg_type, msg_dest, msg_addr}, {1'b1, mk(FE, 4'b0100, 1)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("wait_wb quiet%0d", i), {msg_valid, req_ready}, 2'b00);
    end
    #2 reset = 1'b1;
    #1 check("reset in wait_wb", {msg_valid, req_ready, msg_type, msg_dest, msg_addr}, 11'd0);
    msg_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("ready after mid reset", 32'(req_ready), 1);
    model_req(RM, 1, 1);
    do_req(RM, 1, 1, 0);
    cmp_q("post-reset b1");
    model_req(WM, 0, 3);
    do_req(WM, 0, 3, 0);
    cmp_q("post-reset b3");

    for (int k = 0; k < 150; k++) begin
      logic [1:0] t;
      int n, a;
      t = 2'($urandom_range(3));
      n = $urandom_range(3);
      a = $urandom_range(NB - 1);
      model_req(t, n, a);
      do_req(t, n, a, 30);
      cmp_q($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
